// File: rtl/bcd_seg_scan.sv
// Five-position multiplexed 7-segment driver for signed BCD words, with
// leading-zero and anti-ghost blanking, frame-synchronous display updates and an invalid-nibble pulse.
module bcd_seg_scan #(
  parameter int CLK_DIV     = 1000,
  parameter int BLANK_CYC   = 2,
  parameter int SEG_ACT_LOW = 0,
  parameter int DIG_ACT_LOW = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [16:0] bcd,
  input  logic        bcd_vld,
  output logic [6:0]  seg,
  output logic [4:0]  dig,
  output logic        frame,
  output logic        err
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [6:0] SEG_INV = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [4:0] DIG_INV = (DIG_ACT_LOW != 0) ? 5'h1F : 5'h00;

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [16:0]   r_shadow;
  logic [16:0]   r_disp;
  logic          r_pend;
  logic [6:0]    r_seg;
  logic [4:0]    r_dig;
  logic          r_frame;
  logic          r_err;

  logic          w_tick;
  logic          w_wrap;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_idx_nxt;
  logic [16:0]   w_disp_nxt;
  logic          w_blank;
  logic          w_bad;
  logic [6:0]    w_glyph;
  logic [4:0]    w_dig_nxt;
  logic [6:0]    w_seg_nxt;

  function automatic logic [6:0] f_dec(input logic [3:0] n);
    case (n)
      4'd0:    f_dec = 7'h3F;
      4'd1:    f_dec = 7'h06;
      4'd2:    f_dec = 7'h5B;
      4'd3:    f_dec = 7'h4F;
      4'd4:    f_dec = 7'h66;
      4'd5:    f_dec = 7'h6D;
      4'd6:    f_dec = 7'h7D;
      4'd7:    f_dec = 7'h07;
      4'd8:    f_dec = 7'h7F;
      4'd9:    f_dec = 7'h6F;
      default: f_dec = 7'h79;
    endcase
  endfunction

  assign w_tick     = (r_cnt == CW'(CLK_DIV - 1));
  assign w_wrap     = w_tick && (r_idx == 3'd4);
  assign w_cnt_nxt  = w_tick ? '0 : r_cnt + CW'(1);
  assign w_idx_nxt  = w_tick ? ((r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1) : r_idx;
  assign w_disp_nxt = (w_wrap && r_pend) ? r_shadow : r_disp;
  assign w_blank    = (w_cnt_nxt < CW'(BLANK_CYC));
  assign w_bad      = (bcd[15:12] > 4'd9) || (bcd[11:8] > 4'd9) ||
                      (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);

  // Outputs are registered from next-state values so they line up with cnt/idx.
  always_comb begin
    w_glyph = 7'h00;
    case (w_idx_nxt)
      3'd4: w_glyph = (w_disp_nxt[16] && (w_disp_nxt[15:0] != 16'h0)) ? 7'h40 : 7'h00;
      3'd3: w_glyph = (w_disp_nxt[15:12] == 4'h0) ? 7'h00 : f_dec(w_disp_nxt[15:12]);
      3'd2: w_glyph = (w_disp_nxt[15:8] == 8'h0) ? 7'h00 : f_dec(w_disp_nxt[11:8]);
      3'd1: w_glyph = (w_disp_nxt[15:4] == 12'h0) ? 7'h00 : f_dec(w_disp_nxt[7:4]);
      3'd0: w_glyph = f_dec(w_disp_nxt[3:0]);
      default: w_glyph = 7'h00;
    endcase
  end

  assign w_dig_nxt = w_blank ? 5'h00 : (5'd1 << w_idx_nxt);
  assign w_seg_nxt = w_blank ? 7'h00 : w_glyph;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt    <= '0;
      r_idx    <= 3'd0;
      r_shadow <= 17'h0;
      r_disp   <= 17'h0;
      r_pend   <= 1'b0;
      r_seg    <= SEG_INV;
      r_dig    <= DIG_INV;
      r_frame  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_disp  <= w_disp_nxt;
      if (bcd_vld) r_shadow <= bcd;
      // A word arriving on the transfer edge keeps pending set for the next frame.
      r_pend  <= bcd_vld | (r_pend & ~w_wrap);
      r_frame <= w_wrap;
      r_err   <= bcd_vld & w_bad;
      r_seg   <= w_seg_nxt ^ SEG_INV;
      r_dig   <= w_dig_nxt ^ DIG_INV;
    end
  end

  assign seg   = r_seg;
  assign dig   = r_dig;
  assign frame = r_frame;
  assign err   = r_err;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Bench for bcd_seg_scan: cycle-accurate reference model from the display rules,
// vector table, hand-written timing corners and random word traffic.
module tb_bcd_seg_scan;
  localparam int CD = 8;
  localparam int BC = 2;
  localparam int FP = 5 * CD;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [16:0] bcd = 17'h0;
  logic        bcd_vld = 1'b0;
  logic [6:0]  seg;
  logic [4:0]  dig;
  logic        frame;
  logic        err;

  bcd_seg_scan #(.CLK_DIV(CD), .BLANK_CYC(BC), .SEG_ACT_LOW(0), .DIG_ACT_LOW(0)) dut (
    .clk(clk), .rstn(rstn), .bcd(bcd), .bcd_vld(bcd_vld),
    .seg(seg), .dig(dig), .frame(frame), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          n;
  logic [16:0] m_sh, m_disp;
  bit          m_pend;
  logic [6:0]  e_seg;
  logic [4:0]  e_dig;
  bit          e_frame, e_err;

  typedef struct {
    logic [16:0] b;
    logic [34:0] g;
    logic        e;
  } vec_t;
  vec_t tv[6];

  function automatic logic [6:0] enc(int v);
    case (v)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h79;
    endcase
  endfunction

  function automatic logic [6:0] mglyph(logic [16:0] w, int p);
    int d[4];
    bit lead;
    for (int i = 0; i < 4; i++) d[i] = int'((w >> (4 * i)) & 17'hF);
    if (p == 4) return (w[16] && (d[0] + d[1] + d[2] + d[3] != 0)) ? 7'h40 : 7'h00;
    lead = 1'b1;
    for (int j = p; j < 4; j++) if (d[j] != 0) lead = 1'b0;
    if (p > 0 && lead) return 7'h00;
    return enc(d[p]);
  endfunction

  function automatic bit bad(logic [16:0] w);
    bit r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) if (((w >> (4 * i)) & 17'hF) > 9) r = 1'b1;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at t=%0t (n=%0d)", name, act, exp, $time, n);
    end
  endtask

  task automatic model_reset();
    n = 0; m_sh = 17'h0; m_disp = 17'h0; m_pend = 1'b0;
  endtask

  task automatic model_edge(bit v, logic [16:0] b);
    int c, k;
    n++;
    e_err   = v && bad(b);
    e_frame = (n % FP == 0);
    if (e_frame && m_pend) begin
      m_disp = m_sh;
      m_pend = 1'b0;
    end
    if (v) begin
      m_sh = b;
      m_pend = 1'b1;
    end
    c = n % CD;
    k = (n / CD) % 5;
    e_dig = (c < BC) ? 5'h00 : 5'(1 << k);
    e_seg = (c < BC) ? 7'h00 : mglyph(m_disp, k);
  endtask

  task automatic step();
    bit v;
    logic [16:0] b;
    v = bcd_vld;
    b = bcd;
    @(posedge clk);
    model_edge(v, b);
    #1;
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dig", 32'(dig), 32'(e_dig));
    chk("frame", 32'(frame), 32'(e_frame));
    chk("err", 32'(err), 32'(e_err));
  endtask

  task automatic to_cycle(int m);
    do step(); while ((n % FP) != m);
  endtask

  task automatic pulse(logic [16:0] b);
    bcd = b;
    bcd_vld = 1'b1;
    step();
    bcd_vld = 1'b0;
  endtask

  task automatic chk_rst(string name);
    chk({name, "_seg"}, 32'(seg), 32'h00);
    chk({name, "_dig"}, 32'(dig), 32'h00);
    chk({name, "_frame"}, 32'(frame), 32'h0);
    chk({name, "_err"}, 32'(err), 32'h0);
  endtask

  initial begin
    tv[0] = '{b: 17'h01023, g: {7'h00, 7'h06, 7'h3F, 7'h5B, 7'h4F}, e: 1'b0};
    tv[1] = '{b: 17'h10007, g: {7'h40, 7'h00, 7'h00, 7'h00, 7'h07}, e: 1'b0};
    tv[2] = '{b: 17'h10000, g: {7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}, e: 1'b0};
    tv[3] = '{b: 17'h00A05, g: {7'h00, 7'h00, 7'h79, 7'h3F, 7'h6D}, e: 1'b1};
    tv[4] = '{b: 17'h19999, g: {7'h40, 7'h6F, 7'h6F, 7'h6F, 7'h6F}, e: 1'b0};
    tv[5] = '{b: 17'h0F000, g: {7'h00, 7'h79, 7'h3F, 7'h3F, 7'h3F}, e: 1'b1};

    // Reset and first frame: units '0' only, no frame pulse at the start.
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_rst("reset");
    @(negedge clk) rstn = 1'b1;
    model_reset();
    to_cycle(4);
    chk("first_units", 32'(seg), 32'h3F);
    to_cycle(0);

    // Vector table: word sent mid-frame, shown from the next frame on.
    for (int t = 0; t < 6; t++) begin
      to_cycle(10);
      pulse(tv[t].b);
      chk($sformatf("tv%0d_err", t), 32'(err), 32'(tv[t].e));
      step();
      chk($sformatf("tv%0d_err_clr", t), 32'(err), 32'h0);
      to_cycle(0);
      for (int k = 0; k < 5; k++) begin
        to_cycle(CD * k + 4);
        chk($sformatf("tv%0d_pos%0d", t, k), 32'(seg), 32'(tv[t].g[7 * k +: 7]));
      end
    end

    // Two words in one frame: only the later one appears, at the boundary.
    to_cycle(5);
    pulse(17'h00111);
    to_cycle(20);
    pulse(17'h00222);
    to_cycle(0);
    for (int k = 0; k < 4; k++) begin
      to_cycle(CD * k + 4);
      chk($sformatf("tear_pos%0d", k), 32'(seg), (k < 3) ? 32'h5B : 32'h00);
    end

    // Word on the transfer edge: old shadow shown now, new word one frame later.
    to_cycle(10);
    pulse(17'h00333);
    to_cycle(FP - 1);
    pulse(17'h00444);
    chk("coin_frame", 32'(frame), 32'h1);
    to_cycle(4);
    chk("coin_old", 32'(seg), 32'h4F);
    to_cycle(0);
    to_cycle(4);
    chk("coin_new", 32'(seg), 32'h66);

    // Asynchronous reset at idx=2 with a word pending.
    to_cycle(3);
    pulse(17'h00555);
    to_cycle(2 * CD + 4);
    #2 rstn = 1'b0;
    #1 chk_rst("arst");
    repeat (2) @(posedge clk);
    #1 chk_rst("arst_hold");
    @(negedge clk) rstn = 1'b1;
    model_reset();
    to_cycle(4);
    chk("arst_units", 32'(seg), 32'h3F);
    to_cycle(0);
    to_cycle(4);
    chk("arst_lost", 32'(seg), 32'h3F);

    // Random traffic, including bursts of back-to-back words and invalid nibbles.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        logic [16:0] w;
        w[16] = 1'($urandom_range(0, 1));
        for (int j = 0; j < 4; j++)
          w[4 * j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 11));
        bcd = w;
        bcd_vld = 1'b1;
      end else begin
        bcd_vld = 1'b0;
      end
      step();
    end
    bcd_vld = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
